// File: rtl/sap1_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sap1_controller_pkg
// Description : Opcodes, T-state encodings and the control word for SAP-1.
// Revision    : 1.0 - initial release
// ============================================================================
package sap1_controller_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // Field order fixes the control-word bit positions (cp is the MSB).
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
        logic hlt;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/sap1_controller_ring_counter.sv
`default_nettype none
// ============================================================================
// Module      : sap1_controller_ring_counter
// Description : One-hot rotating ring with sync reset to bit0 and a hold input.
// Revision    : 1.0 - initial release
// ============================================================================
module sap1_controller_ring_counter #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_hold,
    output logic [N-1:0] o_state
);

    logic [N-1:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= {{(N-1){1'b0}}, 1'b1};
        end else if (!i_hold) begin
            r_state <= {r_state[N-2:0], r_state[N-1]};
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/sap1_controller.sv
`default_nettype none
// ============================================================================
// Module      : sap1_controller
// Description : SAP-1 controller-sequencer; T1..T6 ring plus opcode decode.
// Revision    : 1.0 - initial release
// ============================================================================
module sap1_controller
    import sap1_controller_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int N_TSTATES = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] i_opcode,
    output logic                o_cp,
    output logic                o_ep,
    output logic                o_lm,
    output logic                o_ce,
    output logic                o_li,
    output logic                o_ei,
    output logic                o_la,
    output logic                o_ea,
    output logic                o_su,
    output logic                o_eu,
    output logic                o_lb,
    output logic                o_lo,
    output logic                o_hlt,
    output logic [5:0]          o_tstate
);

    logic [N_TSTATES-1:0] w_ring;
    logic                 r_halted;
    ctrl_t                w_ctrl;

    // Once halted the ring is frozen; its value is masked off at the output.
    sap1_controller_ring_counter #(
        .N (N_TSTATES)
    ) u_ring (
        .clk     (clk),
        .rst     (reset),
        .i_hold  (r_halted),
        .o_state (w_ring)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (w_ctrl.hlt) begin
            r_halted <= 1'b1;
        end
    end

    always_comb begin
        w_ctrl = '0;
        if (!reset && !r_halted) begin
            case (w_ring)
                T1: begin w_ctrl.ep = 1'b1; w_ctrl.lm = 1'b1; end
                T2: begin w_ctrl.cp = 1'b1; end
                T3: begin w_ctrl.ce = 1'b1; w_ctrl.li = 1'b1; end
                T4: begin
                    case (i_opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin w_ctrl.ei = 1'b1; w_ctrl.lm = 1'b1; end
                        OP_OUT: begin w_ctrl.ea = 1'b1; w_ctrl.lo = 1'b1; end
                        OP_HLT: begin w_ctrl.hlt = 1'b1; end
                        default: ;
                    endcase
                end
                T5: begin
                    case (i_opcode)
                        OP_LDA: begin w_ctrl.ce = 1'b1; w_ctrl.la = 1'b1; end
                        OP_ADD, OP_SUB: begin w_ctrl.ce = 1'b1; w_ctrl.lb = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    case (i_opcode)
                        OP_ADD: begin w_ctrl.eu = 1'b1; w_ctrl.la = 1'b1; end
                        OP_SUB: begin w_ctrl.su = 1'b1; w_ctrl.eu = 1'b1; w_ctrl.la = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign o_cp  = w_ctrl.cp;
    assign o_ep  = w_ctrl.ep;
    assign o_lm  = w_ctrl.lm;
    assign o_ce  = w_ctrl.ce;
    assign o_li  = w_ctrl.li;
    assign o_ei  = w_ctrl.ei;
    assign o_la  = w_ctrl.la;
    assign o_ea  = w_ctrl.ea;
    assign o_su  = w_ctrl.su;
    assign o_eu  = w_ctrl.eu;
    assign o_lb  = w_ctrl.lb;
    assign o_lo  = w_ctrl.lo;
    assign o_hlt = !reset && (r_halted || w_ctrl.hlt);

    assign o_tstate = reset    ? T1 :
                      r_halted ? 6'b000000 :
                                 6'(w_ring);

endmodule
`default_nettype wire

// File: tb/tb_sap1_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap1_controller
// Description : Directed self-checking bench for the SAP-1 controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sap1_controller;

    localparam logic [12:0] S_CP  = 13'h1000;
    localparam logic [12:0] S_EP  = 13'h0800;
    localparam logic [12:0] S_LM  = 13'h0400;
    localparam logic [12:0] S_CE  = 13'h0200;
    localparam logic [12:0] S_LI  = 13'h0100;
    localparam logic [12:0] S_EI  = 13'h0080;
    localparam logic [12:0] S_LA  = 13'h0040;
    localparam logic [12:0] S_EA  = 13'h0020;
    localparam logic [12:0] S_SU  = 13'h0010;
    localparam logic [12:0] S_EU  = 13'h0008;
    localparam logic [12:0] S_LB  = 13'h0004;
    localparam logic [12:0] S_LO  = 13'h0002;
    localparam logic [12:0] S_HLT = 13'h0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
    logic [5:0] tstate;
    logic [12:0] strobes;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sap1_controller #(
        .OPCODE_W  (4),
        .N_TSTATES (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_opcode (opcode),
        .o_cp     (cp),
        .o_ep     (ep),
        .o_lm     (lm),
        .o_ce     (ce),
        .o_li     (li),
        .o_ei     (ei),
        .o_la     (la),
        .o_ea     (ea),
        .o_su     (su),
        .o_eu     (eu),
        .o_lb     (lb),
        .o_lo     (lo),
        .o_hlt    (hlt),
        .o_tstate (tstate)
    );

    assign strobes = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] ref_ctrl(input int t, input logic [3:0] op);
        logic [12:0] r;
        r = 13'h0;
        case (t)
            0: r = S_EP | S_LM;
            1: r = S_CP;
            2: r = S_CE | S_LI;
            3: case (op)
                   4'h0, 4'h1, 4'h2: r = S_EI | S_LM;
                   4'hE: r = S_EA | S_LO;
                   4'hF: r = S_HLT;
                   default: r = 13'h0;
               endcase
            4: case (op)
                   4'h0: r = S_CE | S_LA;
                   4'h1, 4'h2: r = S_CE | S_LB;
                   default: r = 13'h0;
               endcase
            5: case (op)
                   4'h1: r = S_EU | S_LA;
                   4'h2: r = S_SU | S_EU | S_LA;
                   default: r = 13'h0;
               endcase
            default: r = 13'h0;
        endcase
        return r;
    endfunction

    // Checks strobes and T-state for one cycle, then advances a clock.
    task automatic step_check(input string name, input int t, input logic [3:0] op,
                              input logic [12:0] exp);
        opcode = op;
        #1;
        check($sformatf("%s_T%0d_strobes", name, t + 1), 32'(strobes), 32'(exp));
        check($sformatf("%s_T%0d_tstate", name, t + 1), 32'(tstate), 32'(6'b1 << t));
        tick();
    endtask

    task automatic fetch(input string name, input logic [3:0] op);
        step_check(name, 0, op, S_EP | S_LM);
        step_check(name, 1, op, S_CP);
        step_check(name, 2, op, S_CE | S_LI);
    endtask

    task automatic run_instr(input string name, input logic [3:0] op,
                             input logic [12:0] e4, input logic [12:0] e5, input logic [12:0] e6);
        fetch(name, op);
        step_check(name, 3, op, e4);
        step_check(name, 4, op, e5);
        step_check(name, 5, op, e6);
    endtask

    initial begin
        int t;

        // Reset held for two edges
        reset = 1'b1;
        tick();
        check("rst1_strobes", 32'(strobes), 32'h0);
        check("rst1_tstate", 32'(tstate), 32'h01);
        tick();
        check("rst2_strobes", 32'(strobes), 32'h0);
        check("rst2_tstate", 32'(tstate), 32'h01);
        reset = 1'b0;
        #1;

        run_instr("lda", 4'h0, S_EI | S_LM, S_CE | S_LA, 13'h0);
        run_instr("add", 4'h1, S_EI | S_LM, S_CE | S_LB, S_EU | S_LA);
        run_instr("sub", 4'h2, S_EI | S_LM, S_CE | S_LB, S_SU | S_EU | S_LA);
        run_instr("out", 4'hE, S_EA | S_LO, 13'h0, 13'h0);
        run_instr("nop7", 4'h7, 13'h0, 13'h0, 13'h0);

        // HLT: halt asserted in T4, then frozen regardless of opcode
        fetch("hlt", 4'hF);
        opcode = 4'hF;
        #1;
        check("hlt_T4_strobes", 32'(strobes), 32'(S_HLT));
        check("hlt_T4_tstate", 32'(tstate), 32'h08);
        tick();
        for (int i = 0; i < 20; i++) begin
            opcode = i[0] ? 4'h1 : 4'hE;
            #1;
            check($sformatf("halted%0d_strobes", i), 32'(strobes), 32'(S_HLT));
            check($sformatf("halted%0d_tstate", i), 32'(tstate), 32'h0);
            tick();
        end
        reset = 1'b1;
        #1;
        check("hlt_rst_strobes", 32'(strobes), 32'h0);
        check("hlt_rst_tstate", 32'(tstate), 32'h01);
        tick();
        reset = 1'b0;
        #1;
        check("post_hlt_T1_strobes", 32'(strobes), 32'(S_EP | S_LM));
        check("post_hlt_T1_tstate", 32'(tstate), 32'h01);
        check("post_hlt_hlt", 32'(hlt), 32'h0);
        tick();
        step_check("post_hlt", 1, 4'h0, S_CP);
        step_check("post_hlt", 2, 4'h0, S_CE | S_LI);
        step_check("post_hlt", 3, 4'h0, S_EI | S_LM);
        step_check("post_hlt", 4, 4'h0, S_CE | S_LA);
        step_check("post_hlt", 5, 4'h0, 13'h0);

        // Reset during T5 of ADD aborts the instruction
        fetch("abort", 4'h1);
        step_check("abort", 3, 4'h1, S_EI | S_LM);
        opcode = 4'h1;
        #1;
        check("abort_T5_strobes", 32'(strobes), 32'(S_CE | S_LB));
        reset = 1'b1;
        #1;
        check("abort_rst_strobes", 32'(strobes), 32'h0);
        tick();
        reset = 1'b0;
        run_instr("after_abort", 4'h1, S_EI | S_LM, S_CE | S_LB, S_EU | S_LA);

        // Random opcodes (HLT excluded) against reference table and invariants
        t = 0;
        for (int i = 0; i < 500; i++) begin
            opcode = 4'($urandom_range(0, 14));
            #1;
            check("rnd_strobes", 32'(strobes), 32'(ref_ctrl(t, opcode)));
            check("rnd_excl", 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'h1);
            check("rnd_onehot", 32'($onehot(tstate)), 32'h1);
            check("rnd_la_ea", 32'(la & ea), 32'h0);
            check("rnd_li_ei", 32'(li & ei), 32'h0);
            check("rnd_su_eu", 32'(su & ~eu), 32'h0);
            tick();
            t = (t + 1) % 6;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
